// File: rtl/cmp_counter.sv
// ---------------------------------------------------------------------------
// cmp_counter
//   Single-slope style conversion counter. The analog front end is discharged
//   for RST_CYCLES clocks. Then b counts up from 0 until the synchronised
//   comparator fires or the count saturates. The count at termination is
//   captured into dout, with ovf marking a saturation timeout.
//
// Parameters
//   WIDTH       : count / result width (>= 2)
//   RST_CYCLES  : discharge pulse length in clk cycles (>= 1)
//   SYNC_STAGES : comparator synchroniser depth (>= 1)
//
// Ports
//   clk    : clock, all state on rising edge
//   rst    : synchronous active-high reset
//   en     : enable; low aborts or blocks conversions
//   mode   : 0 = free-run, 1 = single-shot
//   start  : single-shot trigger, looked at only in IDLE
//   cmp    : asynchronous comparator input
//   b      : live count
//   reset  : discharge control, high = discharge
//   dout   : last captured count
//   dvalid : one-cycle pulse, dout/ovf updated in the same cycle
//   ovf    : dout came from a saturation timeout
//   busy   : state is not IDLE
// ---------------------------------------------------------------------------
module cmp_counter #(
   parameter int WIDTH       = 5,
   parameter int RST_CYCLES  = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             start,
   input  logic             cmp,
   output logic [WIDTH-1:0] b,
   output logic             reset,
   output logic [WIDTH-1:0] dout,
   output logic             dvalid,
   output logic             ovf,
   output logic             busy
);

   localparam int DW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [WIDTH-1:0] B_MAX  = {WIDTH{1'b1}};
   localparam logic [DW-1:0]    DIS_END = DW'(RST_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_DISCHARGE = 2'd1,
      S_COUNT     = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       b_q, b_d;
   logic [WIDTH-1:0]       dout_q, dout_d;
   logic                   ovf_q, ovf_d;
   logic                   dvalid_q, dvalid_d;
   logic                   reset_q, reset_d;
   logic                   busy_q, busy_d;
   logic [DW-1:0]          dis_q, dis_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   cmp_s;

   // Oldest synchroniser stage is the only comparator view used below.
   assign cmp_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d[0] = cmp;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

      state_d  = state_q;
      b_d      = b_q;
      dis_d    = dis_q;
      dout_d   = dout_q;
      ovf_d    = ovf_q;
      dvalid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            b_d   = '0;
            dis_d = '0;
            if (en && (!mode || start)) state_d = S_DISCHARGE;
         end

         S_DISCHARGE: begin
            b_d = '0;
            if (!en) begin
               state_d = S_IDLE;
               dis_d   = '0;
            end else if (dis_q == DIS_END) begin
               state_d = S_COUNT;
               dis_d   = '0;
            end else begin
               dis_d = dis_q + DW'(1);
            end
         end

         S_COUNT: begin
            if (!en) begin
               // Abort: no capture, dout/ovf keep the last result.
               state_d = S_IDLE;
               b_d     = '0;
            end else if (cmp_s || (b_q == B_MAX)) begin
               // Comparator has priority over saturation for the ovf flag.
               dout_d   = b_q;
               ovf_d    = !cmp_s;
               dvalid_d = 1'b1;
               b_d      = '0;
               state_d  = mode ? S_IDLE : S_DISCHARGE;
            end else begin
               b_d = b_q + WIDTH'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            b_d     = '0;
            dis_d   = '0;
         end
      endcase

      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      reset_d = (state_d != S_COUNT);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         b_q      <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         dvalid_q <= 1'b0;
         reset_q  <= 1'b1;
         busy_q   <= 1'b0;
         dis_q    <= '0;
         sync_q   <= '0;
      end else begin
         state_q  <= state_d;
         b_q      <= b_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         dvalid_q <= dvalid_d;
         reset_q  <= reset_d;
         busy_q   <= busy_d;
         dis_q    <= dis_d;
         sync_q   <= sync_d;
      end
   end

   assign b      = b_q;
   assign reset  = reset_q;
   assign dout   = dout_q;
   assign dvalid = dvalid_q;
   assign ovf    = ovf_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_cmp_counter.sv
// ---------------------------------------------------------------------------
// tb_cmp_counter
//   Directed bench for cmp_counter with WIDTH=5, RST_CYCLES=2, SYNC_STAGES=2.
//   Inputs change 1 time unit after a rising edge, and outputs are sampled
//   at the same point. With two synchroniser stages, raising cmp right after
//   b reads N makes the counter terminate with b = N+2 captured.
// ---------------------------------------------------------------------------
module tb_cmp_counter;

   logic       clk = 1'b0;
   logic       rst, en, mode, start, cmp;
   logic [4:0] b, dout;
   logic       reset, dvalid, ovf, busy;

   int total = 0;
   int bad   = 0;

   cmp_counter #(.WIDTH(5), .RST_CYCLES(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .cmp(cmp),
      .b(b), .reset(reset), .dout(dout), .dvalid(dvalid), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Checks every output at once; a negative exp_b skips the b check.
   task automatic chk_all(input string tag, input int exp_b, input logic exp_rs,
                          input int exp_dout, input logic exp_dv, input logic exp_ovf,
                          input logic exp_busy);
      if (exp_b >= 0) chk({tag, ".b"}, 32'(b), 32'(exp_b));
      chk({tag, ".reset"},  32'(reset),  32'(exp_rs));
      chk({tag, ".dout"},   32'(dout),   32'(exp_dout));
      chk({tag, ".dvalid"}, 32'(dvalid), 32'(exp_dv));
      chk({tag, ".ovf"},    32'(ovf),    32'(exp_ovf));
      chk({tag, ".busy"},   32'(busy),   32'(exp_busy));
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mode = 1'b0; start = 1'b0; cmp = 1'b1;

      // Reset held 3 cycles with en and cmp high.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all("rst", 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b0; cmp = 1'b0;

      // Free-run: discharge for 2 cycles, then count, cmp_s rises at b=10.
      tick(); chk_all("fr.dis1", 0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      tick(); chk_all("fr.dis2", 0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      tick(); chk_all("fr.cnt0", 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         tick(); chk("fr.b", 32'(b), 32'(k));
      end
      cmp = 1'b1;
      tick(); chk_all("fr.b9",  9,  1'b0, 0, 1'b0, 1'b0, 1'b1);
      tick(); chk_all("fr.b10", 10, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      tick(); chk_all("fr.term", 0, 1'b1, 10, 1'b1, 1'b0, 1'b1);
      cmp = 1'b0;
      tick(); chk_all("fr.dis2b", 0, 1'b1, 10, 1'b0, 1'b0, 1'b1);
      tick(); chk_all("fr.restart", 0, 1'b0, 10, 1'b0, 1'b0, 1'b1);

      // Overflow: cmp held low, b saturates at 31 then times out.
      for (int k = 1; k <= 31; k++) begin
         tick(); chk("ov.b", 32'(b), 32'(k));
      end
      tick(); chk_all("ov.term", 0, 1'b1, 31, 1'b1, 1'b1, 1'b1);
      tick(); chk_all("ov.dis2", 0, 1'b1, 31, 1'b0, 1'b1, 1'b1);
      tick(); chk_all("ov.cnt0", 0, 1'b0, 31, 1'b0, 1'b1, 1'b1);

      // Abort: en dropped while b=7.
      for (int k = 1; k <= 7; k++) begin
         tick(); chk("ab.b", 32'(b), 32'(k));
      end
      en = 1'b0;
      tick(); chk_all("ab.idle", 0, 1'b1, 31, 1'b0, 1'b1, 1'b0);
      tick(); chk_all("ab.stay", 0, 1'b1, 31, 1'b0, 1'b1, 1'b0);

      // Single-shot: nothing happens without start.
      en = 1'b1; mode = 1'b1;
      tick(); chk_all("ss.wait", 0, 1'b1, 31, 1'b0, 1'b1, 1'b0);
      start = 1'b1;
      tick(); chk_all("ss.dis1", 0, 1'b1, 31, 1'b0, 1'b1, 1'b1);
      start = 1'b0;
      tick(); chk_all("ss.dis2", 0, 1'b1, 31, 1'b0, 1'b1, 1'b1);
      tick(); chk_all("ss.cnt0", 0, 1'b0, 31, 1'b0, 1'b1, 1'b1);
      // A start pulse mid-count is ignored; corner: cmp_s rises at b=31.
      for (int k = 1; k <= 29; k++) begin
         tick(); chk("ss.b", 32'(b), 32'(k));
         start = (k == 5);
      end
      start = 1'b0; cmp = 1'b1;
      tick(); chk("ss.b30", 32'(b), 32'd30);
      tick(); chk_all("ss.b31", 31, 1'b0, 31, 1'b0, 1'b1, 1'b1);
      tick(); chk_all("ss.term", 0, 1'b1, 31, 1'b1, 1'b0, 1'b0);
      tick(); chk_all("ss.idle1", 0, 1'b1, 31, 1'b0, 1'b0, 1'b0);
      tick(); chk_all("ss.idle2", 0, 1'b1, 31, 1'b0, 1'b0, 1'b0);

      // cmp high through discharge must not end the conversion early.
      start = 1'b1;
      tick(); chk_all("cd.dis1", 0, 1'b1, 31, 1'b0, 1'b0, 1'b1);
      start = 1'b0;
      tick(); chk_all("cd.dis2", 0, 1'b1, 31, 1'b0, 1'b0, 1'b1);
      tick(); chk_all("cd.cnt0", 0, 1'b0, 31, 1'b0, 1'b0, 1'b1);
      tick(); chk_all("cd.term", 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      cmp = 1'b0;

      // rst mid-conversion: everything cleared, no dvalid.
      mode = 1'b0;
      tick(); chk("rm.busy", 32'(busy), 32'd1);
      tick();
      tick(); chk("rm.reset", 32'(reset), 32'd0);
      tick();
      tick(); chk("rm.b", 32'(b), 32'd2);
      rst = 1'b1;
      tick(); chk_all("rm.rst", 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; en = 1'b0;
      tick(); chk_all("rm.idle", 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
